req_ack_responder: RTL and testbench

// - Responder end of the single-bit req/ack protocol checked by our SVA benches (req |=> ack).
// - Samples req on each clk rising edge and returns a one-cycle ack pulse exactly LATENCY cycles

---
 rtl/req_ack_responder_pkg.sv | 13 +
 rtl/req_ack_responder_if.sv | 15 +
 rtl/req_ack_responder_edge_det.sv | 12 +
 rtl/req_ack_responder.sv | 92 +++++++++
 tb/tb_req_ack_responder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/req_ack_responder_pkg.sv
// Shared types and sizing constants for the req/ack responder.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } resp_state_e;

  localparam int unsigned MAX_LATENCY = 8;
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/req_ack_responder_if.sv
// Handshake bundle between a requester (master) and the responder (slave).
interface req_ack_responder_if;
  import req_ack_pkg::*;

  logic             en;
  logic             req;
  logic             ack;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;
  logic             err_drop;

  modport master (output en, req, input ack, busy, pend_cnt, err_drop);
  modport slave  (input en, req, output ack, busy, pend_cnt, err_drop);

endinterface

// File: rtl/req_ack_responder_edge_det.sv
// Request detector: level mode passes req through, edge mode flags only a 0->1 step.
module req_edge_det #(
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic req,
  input  logic req_q,
  output logic hit_c
);

  assign hit_c = (EDGE_MODE != 0) ? (req & ~req_q) : req;

endmodule

// File: rtl/req_ack_responder.sv
// Responder end of the req/ack protocol: acks each accepted request LATENCY cycles later,
// bounds outstanding requests, and drains in-flight acks when disabled.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned EDGE_MODE = 0
) (
  input logic                clk,
  input logic                rst,
  req_ack_responder_if.slave bus
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("req_ack_responder: LATENCY out of range 1..8");
  end
  if (MAX_OUTST < 1 || MAX_OUTST > 15) begin : g_bad_outst
    $error("req_ack_responder: MAX_OUTST out of range 1..15");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  resp_state_e      state, state_nxt_c;
  logic [LATENCY-1:0] dl;
  logic             req_q;
  logic [CNT_W-1:0] pend_cnt, pend_nxt_c;
  logic             busy;
  logic             err_drop;
  logic             hit_c, live_c, acc_c, retire_c, refuse_c;

  req_edge_det #(.EDGE_MODE(EDGE_MODE)) u_edge_det (
    .req   (bus.req),
    .req_q (req_q),
    .hit_c (hit_c)
  );

  // The ack leaving the delay line frees its slot on the same edge a new request may take it.
  always_comb begin
    retire_c    = dl[LATENCY-1];
    live_c      = hit_c & bus.en & (state != DRAIN);
    acc_c       = live_c & ((pend_cnt < MAX_CNT) | retire_c);
    refuse_c    = live_c & ~acc_c;
    pend_nxt_c  = pend_cnt;
    state_nxt_c = state;

    if (acc_c & ~retire_c) begin
      pend_nxt_c = pend_cnt + CNT_W'(1);
    end else if (retire_c & ~acc_c) begin
      pend_nxt_c = pend_cnt - CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (acc_c) state_nxt_c = ACTIVE;
      end
      ACTIVE: begin
        if (pend_nxt_c == '0) state_nxt_c = IDLE;
        else if (!bus.en)     state_nxt_c = DRAIN;
      end
      DRAIN: begin
        if (pend_nxt_c == '0) state_nxt_c = IDLE;
      end
      default: state_nxt_c = IDLE;
    endcase
  end

  // Delay line, counter, state and status flags; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dl       <= '0;
      req_q    <= 1'b0;
      pend_cnt <= '0;
      busy     <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      state    <= state_nxt_c;
      dl       <= LATENCY'({dl, acc_c});
      req_q    <= bus.req;
      pend_cnt <= pend_nxt_c;
      busy     <= (state_nxt_c != IDLE);
      err_drop <= refuse_c;
    end
  end

  assign bus.ack      = dl[LATENCY-1];
  assign bus.busy     = busy;
  assign bus.pend_cnt = pend_cnt;
  assign bus.err_drop = err_drop;

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: five parameterisations share one stimulus stream and are
// compared against a due-time queue model plus directed expectations.
module tb_req_ack_responder;
  import req_ack_pkg::*;

  localparam int NI = 5;

  function automatic int unsigned lat_of(int i);
    case (i)
      2:       return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned maxo_of(int i);
    case (i)
      2:       return 2;
      4:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int unsigned edge_of(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  logic clk, rst, req, en;
  logic             d_ack  [NI];
  logic             d_busy [NI];
  logic             d_err  [NI];
  logic [CNT_W-1:0] d_pend [NI];

  // Model: each accepted request is stored as the edge at which its ack finishes.
  int  due [NI][$];
  bit  m_ack [NI];
  bit  m_err [NI];
  bit  m_drn [NI];
  bit  m_req_q;
  int  t_cyc;
  int  n_chk;
  int  n_fail;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    req_ack_responder_if ifc ();
    req_ack_responder #(
      .LATENCY   (lat_of(g)),
      .MAX_OUTST (maxo_of(g)),
      .EDGE_MODE (edge_of(g))
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );
    assign ifc.req   = req;
    assign ifc.en    = en;
    assign d_ack[g]  = ifc.ack;
    assign d_busy[g] = ifc.busy;
    assign d_err[g]  = ifc.err_drop;
    assign d_pend[g] = ifc.pend_cnt;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      due[i].delete();
      m_ack[i] = 1'b0;
      m_err[i] = 1'b0;
      m_drn[i] = 1'b0;
    end
    m_req_q = 1'b0;
  endtask

  task automatic model_step();
    t_cyc++;
    for (int i = 0; i < NI; i++) begin
      bit hit, ret, live, acc;
      int used;
      hit  = (edge_of(i) != 0) ? (req && !m_req_q) : (req == 1'b1);
      ret  = (due[i].size() > 0) && (due[i][0] == t_cyc);
      live = hit && (en == 1'b1) && !m_drn[i];
      used = due[i].size() - (ret ? 1 : 0);
      acc  = live && (used < int'(maxo_of(i)));
      if (ret) void'(due[i].pop_front());
      if (acc) due[i].push_back(t_cyc + int'(lat_of(i)));
      m_err[i] = live && !acc;
      m_ack[i] = (due[i].size() > 0) && (due[i][0] == t_cyc + 1);
      m_drn[i] = (due[i].size() > 0) && (m_drn[i] || (en == 1'b0));
    end
    m_req_q = req;
  endtask

  task automatic drive(input logic r, input logic e);
    req = r;
    en  = e;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    repeat (4) drive(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if ({d_ack[i], d_busy[i], d_pend[i], d_err[i]} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset inst=%0d got ack=%b busy=%b pend=%0d err=%b want all 0",
                 i, d_ack[i], d_busy[i], d_pend[i], d_err[i]);
      end
    end
    #6;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_level();
    idle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1);
      n_chk++;
      if ({d_ack[0], d_pend[0]} !== {1'b1, 4'd1}) begin
        n_fail++;
        $display("FAIL level_ack k=%0d got ack=%b pend=%0d want ack=1 pend=1", k, d_ack[0], d_pend[0]);
      end
      n_chk++;
      if ({d_ack[4], d_err[4]} !== 2'b10) begin
        n_fail++;
        $display("FAIL level_max1 k=%0d got ack=%b err=%b want ack=1 err=0", k, d_ack[4], d_err[4]);
      end
    end
    drive(1'b0, 1'b1);
    n_chk++;
    if ({d_ack[0], d_busy[0], d_pend[0]} !== 6'b0) begin
      n_fail++;
      $display("FAIL level_end got ack=%b busy=%b pend=%0d want 0/0/0", d_ack[0], d_busy[0], d_pend[0]);
    end
  endtask

  task automatic test_edge();
    int acks;
    logic [4:0] exp_ack;
    idle();
    acks    = 0;
    exp_ack = 5'b00001;
    for (int k = 0; k < 5; k++) begin
      drive((k < 4) ? 1'b1 : 1'b0, 1'b1);
      if (d_ack[1] === 1'b1) acks++;
      n_chk++;
      if (d_ack[1] !== exp_ack[k]) begin
        n_fail++;
        $display("FAIL edge_ack k=%0d got %b want %b", k, d_ack[1], exp_ack[k]);
      end
    end
    n_chk++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL edge_count got %0d acks want 1", acks);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ea, ee;
    int ep [8];
    idle();
    ea = 8'b0010_1100;
    ee = 8'b0000_0100;
    ep = '{1, 2, 2, 2, 1, 1, 0, 0};
    for (int k = 0; k < 8; k++) begin
      drive((k < 4) ? 1'b1 : 1'b0, 1'b1);
      n_chk++;
      if ({d_ack[2], d_err[2], d_pend[2]} !== {ea[k], ee[k], 4'(ep[k])}) begin
        n_fail++;
        $display("FAIL overflow k=%0d got ack=%b err=%b pend=%0d want ack=%b err=%b pend=%0d",
                 k, d_ack[2], d_err[2], d_pend[2], ea[k], ee[k], ep[k]);
      end
    end
  endtask

  task automatic test_drain();
    logic [5:0] rq, ev, eb, ea;
    int ep [6];
    idle();
    rq = 6'b01_1111;
    ev = 6'b11_1011;
    eb = 6'b00_1111;
    ea = 6'b00_1100;
    ep = '{1, 2, 2, 1, 0, 0};
    for (int k = 0; k < 6; k++) begin
      drive(rq[k], ev[k]);
      n_chk++;
      if ({d_busy[2], d_ack[2], d_err[2], d_pend[2]} !== {eb[k], ea[k], 1'b0, 4'(ep[k])}) begin
        n_fail++;
        $display("FAIL drain k=%0d got busy=%b ack=%b err=%b pend=%0d want busy=%b ack=%b err=0 pend=%0d",
                 k, d_busy[2], d_ack[2], d_err[2], d_pend[2], eb[k], ea[k], ep[k]);
      end
    end
    drive(1'b1, 1'b1);
    n_chk++;
    if ({d_busy[2], d_pend[2]} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL drain_reaccept got busy=%b pend=%0d want busy=1 pend=1", d_busy[2], d_pend[2]);
    end
  endtask

  task automatic test_reset_midflight();
    idle();
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    req = 1'b0;
    n_chk++;
    if (d_pend[2] !== 4'd2) begin
      n_fail++;
      $display("FAIL midrst_pre got pend=%0d want 2", d_pend[2]);
    end
    rst = 1'b1;
    #1;
    for (int i = 2; i < 4; i++) begin
      n_chk++;
      if ({d_ack[i], d_busy[i], d_pend[i]} !== 6'b0) begin
        n_fail++;
        $display("FAIL midrst_now inst=%0d got ack=%b busy=%b pend=%0d want 0/0/0",
                 i, d_ack[i], d_busy[i], d_pend[i]);
      end
    end
    model_reset();
    #2;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1);
      n_chk++;
      if ({d_ack[2], d_ack[3], d_pend[2]} !== 6'b0) begin
        n_fail++;
        $display("FAIL midrst_after k=%0d got ack2=%b ack3=%b pend2=%0d want 0/0/0",
                 k, d_ack[2], d_ack[3], d_pend[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ep [6];
    idle();
    ep = '{1, 2, 2, 2, 2, 2};
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1);
      n_chk++;
      if ({d_ack[3], d_pend[3], d_ack[0]} !== {(k > 0) ? 1'b1 : 1'b0, 4'(ep[k]), 1'b1}) begin
        n_fail++;
        $display("FAIL b2b k=%0d got ack=%b pend=%0d l1ack=%b want ack=%0d pend=%0d l1ack=1",
                 k, d_ack[3], d_pend[3], d_ack[0], (k > 0) ? 1 : 0, ep[k]);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
      end
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) != 0));
      for (int i = 0; i < NI; i++) begin
        logic [6:0] want;
        want = {m_ack[i], due[i].size() > 0, 4'(due[i].size()), m_err[i]};
        n_chk++;
        if ({d_ack[i], d_busy[i], d_pend[i], d_err[i]} !== want) begin
          n_fail++;
          $display("FAIL random inst=%0d cyc=%0d got ack/busy/pend/err=%b/%b/%0d/%b want %b/%b/%0d/%b",
                   i, c, d_ack[i], d_busy[i], d_pend[i], d_err[i],
                   want[6], want[5], want[4:1], want[0]);
        end
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    t_cyc  = 0;
    req    = 1'b0;
    en     = 1'b1;
    model_reset();
    test_reset();
    test_level();
    test_edge();
    test_overflow();
    test_drain();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
